bus_arbiter: RTL

Round-robin arbiter granting the single shared RAM port of the fluxcore datapath to `NUM_REQ` requesters: instruction fetch, the control unit's data accesses, and the debug/program loader. It sits between the requesters and the RAM. It serialises accesses with a request/grant/response handshake and accounts for the RAM's fixed read latency. Only one transaction is in flight at a time.

---
 rtl/bus_arbiter_pkg.sv | 16 +
 rtl/bus_arbiter_rr_picker.sv | 30 +++
 rtl/bus_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the fluxcore RAM-port arbiter: FSM state encoding
// and the round-robin index step used by the arbiter and its picker.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first high req searching from ptr upward,
// wrapping at N. Reusable for any shared resource.
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          any
);

  int unsigned cur;

  always_comb begin
    win = '0;
    any = 1'b0;
    cur = 32'(ptr);
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && req[PW'(cur)]) begin
        win[PW'(cur)] = 1'b1;
        any           = 1'b1;
      end
      cur = rr_next(cur, N);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the single shared RAM port; one transaction in
// flight, IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t         state, state_n;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   sel;
  logic [PTR_W-1:0]   win_idx;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [DATA_W-1:0]  rdata_q;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] win;
  logic               any;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_picker (
    .req (req),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_n = state;
    gnt     = '0;
    rvalid  = '0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (state)
      ARB_IDLE:  if (any) state_n = ARB_ISSUE;
      ARB_ISSUE: begin
        mem_en   = 1'b1;
        mem_we   = sel_we;
        gnt[sel] = 1'b1;
        state_n  = ARB_WAIT;
      end
      ARB_WAIT:  if (cnt == '0) state_n = ARB_RESP;
      ARB_RESP: begin
        rvalid[sel] = 1'b1;
        state_n     = ARB_IDLE;
      end
      default:   state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      sel       <= '0;
      sel_we    <= 1'b0;
      sel_addr  <= '0;
      sel_wdata <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        ARB_IDLE: if (any) begin
          sel       <= win_idx;
          sel_we    <= we[win_idx];
          sel_addr  <= addr_arr[win_idx];
          sel_wdata <= wdata_arr[win_idx];
        end
        ARB_ISSUE: begin
          ptr <= PTR_W'(rr_next(32'(sel), NUM_REQ));
          cnt <= CNT_W'(MEM_LAT - 1);
        end
        // Counter reaching zero marks the cycle mem_rdata is valid.
        ARB_WAIT: begin
          if (cnt == '0) begin
            if (!sel_we) rdata_q <= mem_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign rdata     = rdata_q;

endmodule
